// File: rtl/conv_sched_pkg.sv
// Shared types and default constants for the convolution job scheduler.
package conv_sched_pkg;

    localparam int unsigned DEF_ADDR_W     = 12;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_START_TO   = 8;
    localparam int unsigned DEF_RUN_TO_W   = 16;

    localparam int unsigned NUM_STATES = 5;
    localparam int unsigned JOB_W      = 3 * DEF_ADDR_W;

    // One-hot scheduler states
    typedef enum logic [NUM_STATES-1:0] {
        S_IDLE   = 5'b00001,
        S_LAUNCH = 5'b00010,
        S_WAIT   = 5'b00100,
        S_RUN    = 5'b01000,
        S_DONE   = 5'b10000
    } state_e;

    // Job payload at the default address width: {in_base, out_base, wgt_addr}
    typedef struct packed {
        logic [DEF_ADDR_W-1:0] in_base;
        logic [DEF_ADDR_W-1:0] out_base;
        logic [DEF_ADDR_W-1:0] wgt_addr;
    } job_t;

    // Packed job width for an arbitrary address width
    function automatic int unsigned job_w(input int unsigned addr_w);
        return 3 * addr_w;
    endfunction

endpackage

// File: rtl/job_fifo.sv
// Registered job queue: no fall-through, status flags are flops.
module job_fifo
    import conv_sched_pkg::*;
#(
    parameter int unsigned W     = JOB_W,
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_b,
    input  logic                      push,
    input  logic                      pop,
    input  logic [W-1:0]              din,
    output logic [W-1:0]              dout,
    output logic                      full,
    output logic                      empty,
    output logic                      not_full,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          not_full_q, not_full_d;
    logic          push_ok;
    logic          pop_ok;

    // Pointer, count and flag update; a full queue refuses pushes even on a pop
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push & ~full_q;
        pop_ok   = pop & ~empty_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d    = count_q + CW'(push_ok) - CW'(pop_ok);
        full_d     = (count_d == CW'(DEPTH));
        empty_d    = (count_d == '0);
        not_full_d = ~full_d;
    end

    // Control state
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            not_full_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            not_full_q <= not_full_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by the count
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout     = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign not_full = not_full_q;
    assign count    = count_q;

endmodule

// File: rtl/conv_job_scheduler.sv
// Queues convolution jobs and sequences the engine's run/busy handshake with timeouts.
module conv_job_scheduler
    import conv_sched_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned START_TO   = DEF_START_TO,
    parameter int unsigned RUN_TO_W   = DEF_RUN_TO_W
) (
    input  logic                          clk,
    input  logic                          reset_b,
    input  logic                          job_valid,
    output logic                          job_ready,
    input  logic [ADDR_W-1:0]             job_in_base,
    input  logic [ADDR_W-1:0]             job_out_base,
    input  logic [ADDR_W-1:0]             job_wgt_addr,
    output logic                          eng_run,
    input  logic                          eng_busy,
    output logic [ADDR_W-1:0]             eng_in_base,
    output logic [ADDR_W-1:0]             eng_out_base,
    output logic [ADDR_W-1:0]             eng_wgt_addr,
    output logic                          sched_busy,
    output logic                          done_pulse,
    output logic [7:0]                    jobs_done,
    output logic                          start_err,
    output logic                          run_err,
    input  logic                          err_clr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned JW = job_w(ADDR_W);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned TW = RUN_TO_W;

    state_e            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [ADDR_W-1:0] eng_in_q, eng_in_d;
    logic [ADDR_W-1:0] eng_out_q, eng_out_d;
    logic [ADDR_W-1:0] eng_wgt_q, eng_wgt_d;
    logic              eng_run_q, eng_run_d;
    logic              done_pulse_q, done_pulse_d;
    logic              sched_busy_q, sched_busy_d;
    logic              start_err_q, start_err_d;
    logic              run_err_q, run_err_d;
    logic [7:0]        jobs_done_q, jobs_done_d;

    logic              push;
    logic              pop;
    logic              set_start;
    logic              set_run;
    logic              retire_ok;
    logic [JW-1:0]     fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_not_full;
    logic [CW-1:0]     fifo_count_w;
    logic [CW-1:0]     fifo_count_d;

    assign push = job_valid & ~fifo_full;

    // Job queue
    job_fifo #(
        .W     (JW),
        .DEPTH (FIFO_DEPTH)
    ) u_job_fifo (
        .clk      (clk),
        .reset_b  (reset_b),
        .push     (push),
        .pop      (pop),
        .din      ({job_in_base, job_out_base, job_wgt_addr}),
        .dout     (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .not_full (fifo_not_full),
        .count    (fifo_count_w)
    );

    // Next-state, timer, error and output decode
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        eng_in_d  = eng_in_q;
        eng_out_d = eng_out_q;
        eng_wgt_d = eng_wgt_q;
        pop       = 1'b0;
        set_start = 1'b0;
        set_run   = 1'b0;
        retire_ok = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    eng_in_d  = fifo_dout[3*ADDR_W-1:2*ADDR_W];
                    eng_out_d = fifo_dout[2*ADDR_W-1:ADDR_W];
                    eng_wgt_d = fifo_dout[ADDR_W-1:0];
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Busy seen here belongs to a previous job and is ignored
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (eng_busy) begin
                    timer_d = '0;
                    state_d = S_RUN;
                end else if (timer_q == TW'(START_TO - 1)) begin
                    set_start = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RUN: begin
                if (!eng_busy) begin
                    retire_ok = 1'b1;
                    state_d   = S_DONE;
                end else if (&timer_q) begin
                    // Engine is left running; the host must inspect run_err
                    set_run = 1'b1;
                    state_d = S_DONE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        start_err_d  = err_clr ? 1'b0 : (start_err_q | set_start);
        run_err_d    = err_clr ? 1'b0 : (run_err_q | set_run);
        jobs_done_d  = jobs_done_q + 8'(retire_ok);
        eng_run_d    = (state_d == S_LAUNCH);
        done_pulse_d = (state_d == S_DONE);
        fifo_count_d = fifo_count_w + CW'(push) - CW'(pop);
        sched_busy_d = (fifo_count_d != '0) || (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q      <= S_IDLE;
            timer_q      <= '0;
            eng_in_q     <= '0;
            eng_out_q    <= '0;
            eng_wgt_q    <= '0;
            eng_run_q    <= 1'b0;
            done_pulse_q <= 1'b0;
            sched_busy_q <= 1'b0;
            start_err_q  <= 1'b0;
            run_err_q    <= 1'b0;
            jobs_done_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            eng_in_q     <= eng_in_d;
            eng_out_q    <= eng_out_d;
            eng_wgt_q    <= eng_wgt_d;
            eng_run_q    <= eng_run_d;
            done_pulse_q <= done_pulse_d;
            sched_busy_q <= sched_busy_d;
            start_err_q  <= start_err_d;
            run_err_q    <= run_err_d;
            jobs_done_q  <= jobs_done_d;
        end
    end

    assign job_ready    = fifo_not_full;
    assign fifo_count   = fifo_count_w;
    assign eng_run      = eng_run_q;
    assign eng_in_base  = eng_in_q;
    assign eng_out_base = eng_out_q;
    assign eng_wgt_addr = eng_wgt_q;
    assign sched_busy   = sched_busy_q;
    assign done_pulse   = done_pulse_q;
    assign jobs_done    = jobs_done_q;
    assign start_err    = start_err_q;
    assign run_err      = run_err_q;

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler: a default instance plus a RUN_TO_W=4 instance.
module tb_conv_job_scheduler;

    logic        clk;
    logic        reset_b;
    logic        job_valid;
    logic [11:0] job_in_base, job_out_base, job_wgt_addr;
    logic        eng_busy;
    logic        err_clr;

    logic        job_ready, eng_run, sched_busy, done_pulse, start_err, run_err;
    logic [11:0] eng_in_base, eng_out_base, eng_wgt_addr;
    logic [7:0]  jobs_done;
    logic [2:0]  fifo_count;

    logic        job_ready4, eng_run4, sched_busy4, done_pulse4, start_err4, run_err4;
    logic [11:0] eng_in_base4, eng_out_base4, eng_wgt_addr4;
    logic [7:0]  jobs_done4;
    logic [2:0]  fifo_count4;

    int n_tests;
    int n_fail;
    int eng_len;
    logic model_active;
    int done_cnt;
    int run_cnt;
    logic [11:0] mon_in  [1024];
    logic [11:0] mon_out [1024];
    logic [11:0] mon_wgt [1024];

    conv_job_scheduler dut (
        .clk(clk), .reset_b(reset_b), .job_valid(job_valid), .job_ready(job_ready),
        .job_in_base(job_in_base), .job_out_base(job_out_base), .job_wgt_addr(job_wgt_addr),
        .eng_run(eng_run), .eng_busy(eng_busy), .eng_in_base(eng_in_base),
        .eng_out_base(eng_out_base), .eng_wgt_addr(eng_wgt_addr), .sched_busy(sched_busy),
        .done_pulse(done_pulse), .jobs_done(jobs_done), .start_err(start_err),
        .run_err(run_err), .err_clr(err_clr), .fifo_count(fifo_count)
    );

    conv_job_scheduler #(.RUN_TO_W(4)) dut4 (
        .clk(clk), .reset_b(reset_b), .job_valid(job_valid), .job_ready(job_ready4),
        .job_in_base(job_in_base), .job_out_base(job_out_base), .job_wgt_addr(job_wgt_addr),
        .eng_run(eng_run4), .eng_busy(eng_busy), .eng_in_base(eng_in_base4),
        .eng_out_base(eng_out_base4), .eng_wgt_addr(eng_wgt_addr4), .sched_busy(sched_busy4),
        .done_pulse(done_pulse4), .jobs_done(jobs_done4), .start_err(start_err4),
        .run_err(run_err4), .err_clr(err_clr), .fifo_count(fifo_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: busy rises the cycle after eng_run and stays high eng_len cycles
    initial begin
        eng_busy = 1'b0;
        model_active = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (eng_run && eng_len != 0) begin
                model_active = 1'b1;
                @(posedge clk); #1;
                eng_busy = 1'b1;
                repeat (eng_len) begin
                    @(posedge clk); #1;
                end
                eng_busy = 1'b0;
                model_active = 1'b0;
            end
        end
    end

    // Monitor: records retired job addresses and counts run pulses
    initial begin
        done_cnt = 0;
        run_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (done_pulse) begin
                mon_in[done_cnt % 1024]  = eng_in_base;
                mon_out[done_cnt % 1024] = eng_out_base;
                mon_wgt[done_cnt % 1024] = eng_wgt_addr;
                done_cnt++;
            end
            if (eng_run) run_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        for (int i = 0; i < 100 && model_active; i++) tick();
        reset_b = 1'b0;
        job_valid = 1'b0;
        err_clr = 1'b0;
        tick();
        tick();
        reset_b = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        tick();
        n_tests++;
        if (job_ready !== 1'b1 || job_ready4 !== 1'b1) begin
            n_fail++; $display("FAIL reset_job_ready: got %b/%b expected 1/1", job_ready, job_ready4);
        end
        n_tests++;
        if ({eng_run, sched_busy, done_pulse, start_err, run_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {eng_run, sched_busy, done_pulse, start_err, run_err});
        end
        n_tests++;
        if ({jobs_done, fifo_count, eng_in_base, eng_out_base, eng_wgt_addr} !== 47'h0) begin
            n_fail++; $display("FAIL reset_values: got jobs=%0d cnt=%0d addr=%h/%h/%h expected all 0", jobs_done, fifo_count, eng_in_base, eng_out_base, eng_wgt_addr);
        end
        reset_b = 1'b1;
        tick();
        n_tests++;
        if (job_ready !== 1'b1 || sched_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got ready=%b busy=%b expected 1/0", job_ready, sched_busy);
        end
    endtask

    task automatic test_single_job();
        int run_base;
        int done_seen;
        int bad_addr;
        do_reset();
        eng_len = 40;
        run_base = run_cnt;
        job_in_base = 12'h000; job_out_base = 12'h100; job_wgt_addr = 12'h001;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        n_tests++;
        if (fifo_count !== 3'd1 || eng_run !== 1'b0 || sched_busy !== 1'b1) begin
            n_fail++; $display("FAIL single_t1: got cnt=%0d run=%b busy=%b expected 1/0/1", fifo_count, eng_run, sched_busy);
        end
        tick();
        n_tests++;
        if (eng_run !== 1'b1) begin
            n_fail++; $display("FAIL single_run_t2: got %b expected 1", eng_run);
        end
        n_tests++;
        if ({eng_in_base, eng_out_base, eng_wgt_addr} !== 36'h000100001) begin
            n_fail++; $display("FAIL single_addr: got %h expected 000100001", {eng_in_base, eng_out_base, eng_wgt_addr});
        end
        tick();
        n_tests++;
        if (eng_run !== 1'b0) begin
            n_fail++; $display("FAIL single_run_t3: got %b expected 0", eng_run);
        end
        done_seen = 0;
        bad_addr = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_pulse) done_seen++;
            if ({eng_in_base, eng_out_base, eng_wgt_addr} !== 36'h000100001) bad_addr++;
        end
        n_tests++;
        if (done_seen != 0 || bad_addr != 0) begin
            n_fail++; $display("FAIL single_hold: got early_done=%0d addr_changes=%0d expected 0/0", done_seen, bad_addr);
        end
        tick();
        n_tests++;
        if (done_pulse !== 1'b1 || jobs_done !== 8'd1) begin
            n_fail++; $display("FAIL single_done: got pulse=%b jobs=%0d expected 1/1", done_pulse, jobs_done);
        end
        n_tests++;
        if (start_err !== 1'b0 || run_err !== 1'b0) begin
            n_fail++; $display("FAIL single_errs: got %b%b expected 00", start_err, run_err);
        end
        tick();
        n_tests++;
        if (done_pulse !== 1'b0 || sched_busy !== 1'b0 || (run_cnt - run_base) != 1) begin
            n_fail++; $display("FAIL single_after: got pulse=%b busy=%b runs=%0d expected 0/0/1", done_pulse, sched_busy, run_cnt - run_base);
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] e_in [6];
        logic [11:0] e_out [6];
        logic [11:0] e_wgt [6];
        int base;
        int w;
        int early_stall;
        do_reset();
        eng_len = 6;
        base = done_cnt;
        early_stall = 0;
        for (int i = 0; i < 6; i++) begin
            e_in[i]  = 12'(12'h040 + i);
            e_out[i] = 12'(12'h800 + 16 * i);
            e_wgt[i] = 12'(3 * i + 5);
        end
        for (int i = 0; i < 6; i++) begin
            job_in_base = e_in[i]; job_out_base = e_out[i]; job_wgt_addr = e_wgt[i];
            job_valid = 1'b1;
            if (i == 5) begin
                n_tests++;
                if (job_ready !== 1'b0 || fifo_count !== 3'd4) begin
                    n_fail++; $display("FAIL b2b_full: got ready=%b cnt=%0d expected 0/4", job_ready, fifo_count);
                end
            end
            w = 0;
            while (!job_ready && w < 50) begin
                tick();
                w++;
            end
            if (i < 5) early_stall += w;
            if (i == 5) begin
                n_tests++;
                if (w != 7) begin
                    n_fail++; $display("FAIL b2b_stall: got %0d stalled cycles expected 7", w);
                end
            end
            tick();
        end
        job_valid = 1'b0;
        n_tests++;
        if (early_stall != 0) begin
            n_fail++; $display("FAIL b2b_early_stall: got %0d expected 0", early_stall);
        end
        for (int i = 0; i < 400 && (done_cnt - base) < 6; i++) tick();
        tick();
        n_tests++;
        if ((done_cnt - base) != 6 || jobs_done !== 8'd6) begin
            n_fail++; $display("FAIL b2b_count: got retired=%0d jobs=%0d expected 6/6", done_cnt - base, jobs_done);
        end
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if ({mon_in[(base + i) % 1024], mon_out[(base + i) % 1024], mon_wgt[(base + i) % 1024]} !== {e_in[i], e_out[i], e_wgt[i]}) begin
                n_fail++; $display("FAIL b2b_order job%0d: got %h/%h/%h expected %h/%h/%h", i, mon_in[(base + i) % 1024], mon_out[(base + i) % 1024], mon_wgt[(base + i) % 1024], e_in[i], e_out[i], e_wgt[i]);
            end
        end
    endtask

    task automatic test_start_timeout();
        int w;
        do_reset();
        eng_len = 0;
        job_in_base = 12'h111; job_out_base = 12'h222; job_wgt_addr = 12'h333;
        job_valid = 1'b1;
        tick();
        job_in_base = 12'h444; job_out_base = 12'h555; job_wgt_addr = 12'h666;
        tick();
        job_valid = 1'b0;
        n_tests++;
        if (eng_run !== 1'b1) begin
            n_fail++; $display("FAIL start_launch: got %b expected 1", eng_run);
        end
        repeat (8) tick();
        n_tests++;
        if (start_err !== 1'b0 || done_pulse !== 1'b0) begin
            n_fail++; $display("FAIL start_early: got err=%b pulse=%b expected 0/0", start_err, done_pulse);
        end
        tick();
        n_tests++;
        if (start_err !== 1'b1 || done_pulse !== 1'b1 || jobs_done !== 8'd0) begin
            n_fail++; $display("FAIL start_err: got err=%b pulse=%b jobs=%0d expected 1/1/0", start_err, done_pulse, jobs_done);
        end
        eng_len = 3;
        tick();
        n_tests++;
        if (done_pulse !== 1'b0) begin
            n_fail++; $display("FAIL start_single_pulse: got %b expected 0", done_pulse);
        end
        tick();
        n_tests++;
        if (eng_run !== 1'b1 || eng_in_base !== 12'h444) begin
            n_fail++; $display("FAIL start_next_launch: got run=%b in=%h expected 1/444", eng_run, eng_in_base);
        end
        w = 0;
        while (!done_pulse && w < 40) begin
            tick();
            w++;
        end
        n_tests++;
        if (done_pulse !== 1'b1 || jobs_done !== 8'd1 || start_err !== 1'b1) begin
            n_fail++; $display("FAIL start_next_done: got pulse=%b jobs=%0d err=%b expected 1/1/1", done_pulse, jobs_done, start_err);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tests++;
        if (start_err !== 1'b0) begin
            n_fail++; $display("FAIL start_clr: got %b expected 0", start_err);
        end
    endtask

    task automatic test_run_timeout();
        // Phase 1: run timeout fires after 15 timer counts
        do_reset();
        eng_len = 30;
        job_in_base = 12'h0AA; job_out_base = 12'h0BB; job_wgt_addr = 12'h0CC;
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        repeat (18) tick();
        n_tests++;
        if (run_err4 !== 1'b0 || done_pulse4 !== 1'b0) begin
            n_fail++; $display("FAIL run_early: got err=%b pulse=%b expected 0/0", run_err4, done_pulse4);
        end
        tick();
        n_tests++;
        if (run_err4 !== 1'b1 || done_pulse4 !== 1'b1 || jobs_done4 !== 8'd0) begin
            n_fail++; $display("FAIL run_err: got err=%b pulse=%b jobs=%0d expected 1/1/0", run_err4, done_pulse4, jobs_done4);
        end
        n_tests++;
        if (run_err !== 1'b0 || sched_busy !== 1'b1) begin
            n_fail++; $display("FAIL run_wide_timer: got err=%b busy=%b expected 0/1", run_err, sched_busy);
        end
        // Phase 2: err_clr in the cycle the error would set wins
        do_reset();
        job_valid = 1'b1;
        tick();
        job_valid = 1'b0;
        repeat (18) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_tests++;
        if (run_err4 !== 1'b0 || done_pulse4 !== 1'b1) begin
            n_fail++; $display("FAIL run_clr_priority: got err=%b pulse=%b expected 0/1", run_err4, done_pulse4);
        end
    endtask

    task automatic test_reset_mid_job();
        int run_base;
        do_reset();
        eng_len = 30;
        job_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            job_in_base = 12'(12'h300 + i); job_out_base = 12'h7F0; job_wgt_addr = 12'(i);
            tick();
        end
        job_valid = 1'b0;
        repeat (7) tick();
        n_tests++;
        if (fifo_count !== 3'd2 || sched_busy !== 1'b1) begin
            n_fail++; $display("FAIL mid_prereset: got cnt=%0d busy=%b expected 2/1", fifo_count, sched_busy);
        end
        #3;
        reset_b = 1'b0;
        #1;
        n_tests++;
        if (fifo_count !== 3'd0 || job_ready !== 1'b1 || sched_busy !== 1'b0 || eng_run !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got cnt=%0d ready=%b busy=%b run=%b expected 0/1/0/0", fifo_count, job_ready, sched_busy, eng_run);
        end
        n_tests++;
        if ({eng_in_base, eng_out_base, eng_wgt_addr} !== 36'h0 || jobs_done !== 8'd0) begin
            n_fail++; $display("FAIL mid_async_regs: got %h jobs=%0d expected 0/0", {eng_in_base, eng_out_base, eng_wgt_addr}, jobs_done);
        end
        tick();
        tick();
        reset_b = 1'b1;
        run_base = run_cnt;
        repeat (20) tick();
        n_tests++;
        if ((run_cnt - run_base) != 0 || fifo_count !== 3'd0) begin
            n_fail++; $display("FAIL mid_release: got runs=%0d cnt=%0d expected 0/0", run_cnt - run_base, fifo_count);
        end
    endtask

    task automatic test_wrap();
        int base;
        int w;
        int stuck;
        do_reset();
        eng_len = 1;
        base = done_cnt;
        stuck = 0;
        for (int i = 0; i < 256; i++) begin
            job_in_base = 12'(i); job_out_base = 12'(i + 1); job_wgt_addr = 12'(i + 2);
            job_valid = 1'b1;
            w = 0;
            while (!job_ready && w < 50) begin
                tick();
                w++;
            end
            if (w >= 50) stuck++;
            tick();
        end
        job_valid = 1'b0;
        for (int i = 0; i < 4000 && (done_cnt - base) < 256; i++) tick();
        repeat (5) tick();
        n_tests++;
        if (stuck != 0 || (done_cnt - base) != 256) begin
            n_fail++; $display("FAIL wrap_count: got retired=%0d stuck=%0d expected 256/0", done_cnt - base, stuck);
        end
        n_tests++;
        if (jobs_done !== 8'd0 || start_err !== 1'b0 || run_err !== 1'b0) begin
            n_fail++; $display("FAIL wrap_jobs_done: got jobs=%0d errs=%b%b expected 0/00", jobs_done, start_err, run_err);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail = 0;
        eng_len = 0;
        reset_b = 1'b0;
        job_valid = 1'b0;
        job_in_base = '0;
        job_out_base = '0;
        job_wgt_addr = '0;
        err_clr = 1'b0;
        tick();
        test_reset();
        test_single_job();
        test_back_to_back();
        test_start_timeout();
        test_run_timeout();
        test_reset_mid_job();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
